parc_core_scoreboard: RTL and testbench
=======================================

# parc_core_scoreboard

Per-register scoreboard and hazard controller for the 5-stage PARCv2 long-latency pipeline. It sits in the control unit beside the decode stage. It tracks every in-flight register write by producing unit and pipeline position, and drives the op0/op1 bypass mux selects and the decode-stage RAW hazard stall consumed by the datapath. It also keeps a hazard-stall performance counter.

## Interface
- No parameters; 32 architectural registers, r0 never tracked.
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clears all state
- inst_val_Dhl  in  1  valid instruction in D
- rs_Dhl / rt_Dhl  in  5 each  source register specifiers
- rs_en_Dhl / rt_en_Dhl  in  1 each  source actually read
- rd_Dhl  in  5  destination register
- wen_Dhl  in  1  instruction writes rd
- fu_Dhl  in  2  producer: 0 ALU, 1 load, 2 muldiv (3 illegal, treated as ALU)
- issue_Dhl  in  1  instruction leaves D into X at this edge (ctrl guarantees valid, unstalled, unsquashed)
- advance_Xhl / advance_Mhl / advance_Whl  in  1 each  occupant of X/M/W moves on (W: retires) at this edge
- muldivresp_val_Xhl  in  1  muldiv result present in X this cycle
- dmemresp_val_Mhl  in  1  load data present in M this cycle (direct or queued)
- op0_byp_mux_sel_Dhl / op1_byp_mux_sel_Dhl  out  2 each  00 RF, 01 X, 10 M, 11 W
- stall_hazard_Dhl  out  1  D must stall for unready operand
- hazard_stall_count  out  32  cycles with inst_val_Dhl & stall_hazard_Dhl

## Operation
- Per-register state: pending, stage (X=1, M=2, W=3), fu (2b), ready.
- Issue (issue_Dhl & wen_Dhl & rd_Dhl≠0): entry[rd] ← pending=1, stage=X, fu=fu_Dhl, ready=(fu==ALU). Overwrites any older entry for rd (WAW: youngest producer wins).
- Advance, per pending entry not being issued this edge:
  - stage X & advance_Xhl → M
  - stage M & advance_Mhl → W
  - stage W & advance_Whl → pending=0
- Ready capture: ready ← 1 when stage==X & fu==muldiv & muldivresp_val_Xhl, or stage==M & fu==load & dmemresp_val_Mhl. Once set, ready holds until the entry is cleared or overwritten.
- Effective ready (combinational) = ready | the same two capture terms in the current cycle.
- Per source s (rs, rt), when en & s≠0 & pending[s]:
  - if effective ready, sel = stage code (X→01, M→10, W→11)
  - otherwise, source is unready
  - all other cases: sel=00
- stall_hazard_Dhl = inst_val_Dhl & (rs unready | rt unready).
- Older producer retiring from W while entry[rd] tracks a younger producer: no effect. Entry advances only on its own stage's advance.
- Counter increments by 1 per qualifying cycle and wraps at 2^32−1 → 0.
- ctrl guarantees a load/muldiv never advances out of M/X unready. The scoreboard does not check this.

## Timing
- Outputs are combinational from registered state plus current-cycle response valids. Zero-cycle lookup.
- State updates at posedge.
- Issue at edge t: consumer in D during cycle t+1 sees stage X.
- ALU producer → consumer gets 01, no stall.
- Load producer → consumer stalls ≥1 cycle. It gets 10 in the first cycle dmemresp_val_Mhl is high with the load in M.
- Muldiv producer → consumer stalls until muldivresp_val_Xhl, then gets 01 that cycle.
- Issue to rd on the same edge the old rd entry retires from W: issue wins, pending=1, stage=X.
- Reading a register while its producer is in W with advance_Whl: still sel 11 that cycle. The RF write lands at the edge.
- Reset:
  - all pending=0, counter=0
  - after reset: sels 00, stall_hazard_Dhl=0, hazard_stall_count=0
  - reset mid-flight discards all entries, with no stall on the next cycle

## Test plan
- ALU chain: addu r3 issued t, consumer reads r3 at t+1,t+2,t+3 with all advances=1 → sel 01, 10, 11. At t+4 → 00, stall never asserted.
- Load-use: lw r5 issued t, consumer rs=r5; dmemresp_val_Mhl high at t+2 → stall=1 at t+1, sel 10 and stall=0 at t+2, counter=1.
- Muldiv 4-cycle: mul r7 issued t, muldivresp_val_Xhl at t+4 with advance_Xhl=0 before → stall t+1..t+3, sel 01 at t+4, counter=3.
- WAW: lw r2 then addu r2 issued back-to-back, consumer of r2 → follows addu (01, no stall). Lw retiring from W does not clear r2 pending.
- r0 and disabled sources: rd=0 issue, rs=0, rt_en=0 with pending rt → sels 00, no stall.
- Reset mid-stall: muldiv pending and stall=1, reset one cycle → next cycle stall=0, sels 00, counter=0.

Source files
------------

// File: rtl/parc_core_scoreboard.sv
// Register scoreboard for the PARCv2 long-latency pipeline: tracks in-flight
// writers per register, drives D-stage bypass selects, RAW stall and stall counter.
module parc_core_scoreboard (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_val_Dhl,
   input  logic [4:0]  rs_Dhl,
   input  logic [4:0]  rt_Dhl,
   input  logic        rs_en_Dhl,
   input  logic        rt_en_Dhl,
   input  logic [4:0]  rd_Dhl,
   input  logic        wen_Dhl,
   input  logic [1:0]  fu_Dhl,
   input  logic        issue_Dhl,
   input  logic        advance_Xhl,
   input  logic        advance_Mhl,
   input  logic        advance_Whl,
   input  logic        muldivresp_val_Xhl,
   input  logic        dmemresp_val_Mhl,
   output logic [1:0]  op0_byp_mux_sel_Dhl,
   output logic [1:0]  op1_byp_mux_sel_Dhl,
   output logic        stall_hazard_Dhl,
   output logic [31:0] hazard_stall_count
);

   localparam logic [1:0] FU_ALU = 2'd0;
   localparam logic [1:0] FU_LD  = 2'd1;
   localparam logic [1:0] FU_MD  = 2'd2;

   // Stage codes double as the bypass select for that stage.
   localparam logic [1:0] STG_X  = 2'd1;
   localparam logic [1:0] STG_M  = 2'd2;
   localparam logic [1:0] STG_W  = 2'd3;

   logic [31:0] pending_q, pending_d;
   logic [31:0] ready_q,   ready_d;
   logic [1:0]  stage_q [32];
   logic [1:0]  stage_d [32];
   logic [1:0]  fu_q    [32];
   logic [1:0]  fu_d    [32];
   logic [31:0] count_q, count_d;

   logic [31:0] capture_w;
   logic [31:0] eff_ready_w;
   logic        rs_hit_w, rt_hit_w;
   logic        rs_unrdy_w, rt_unrdy_w;
   logic [1:0]  fu_issue_w;

   function automatic logic capture_term(input logic [1:0] stage,
                                         input logic [1:0] fu,
                                         input logic       md_val,
                                         input logic       ld_val);
      capture_term = ((stage == STG_X) && (fu == FU_MD) && md_val) ||
                     ((stage == STG_M) && (fu == FU_LD) && ld_val);
   endfunction

   // Illegal fu code 3 is folded into ALU at issue so nothing downstream sees it.
   assign fu_issue_w = (fu_Dhl == FU_LD || fu_Dhl == FU_MD) ? fu_Dhl : FU_ALU;

   always_comb begin
      for (int i = 0; i < 32; i++) begin
         capture_w[i]   = capture_term(stage_q[i], fu_q[i],
                                       muldivresp_val_Xhl, dmemresp_val_Mhl);
         eff_ready_w[i] = ready_q[i] | capture_w[i];
      end
   end

   always_comb begin
      pending_d = pending_q;
      ready_d   = ready_q;
      stage_d   = stage_q;
      fu_d      = fu_q;
      for (int i = 1; i < 32; i++) begin
         if (issue_Dhl && wen_Dhl && (rd_Dhl == 5'(i))) begin
            // Youngest producer replaces any older one, even one retiring now.
            pending_d[i] = 1'b1;
            stage_d[i]   = STG_X;
            fu_d[i]      = fu_issue_w;
            ready_d[i]   = (fu_issue_w == FU_ALU);
         end else if (pending_q[i]) begin
            if (capture_w[i])
               ready_d[i] = 1'b1;
            case (stage_q[i])
               STG_X:   if (advance_Xhl) stage_d[i] = STG_M;
               STG_M:   if (advance_Mhl) stage_d[i] = STG_W;
               STG_W:   if (advance_Whl) begin
                           pending_d[i] = 1'b0;
                           ready_d[i]   = 1'b0;
                        end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rs_hit_w   = rs_en_Dhl && (rs_Dhl != 5'd0) && pending_q[rs_Dhl];
      rt_hit_w   = rt_en_Dhl && (rt_Dhl != 5'd0) && pending_q[rt_Dhl];
      rs_unrdy_w = rs_hit_w && !eff_ready_w[rs_Dhl];
      rt_unrdy_w = rt_hit_w && !eff_ready_w[rt_Dhl];

      op0_byp_mux_sel_Dhl = 2'b00;
      op1_byp_mux_sel_Dhl = 2'b00;
      if (rs_hit_w && eff_ready_w[rs_Dhl])
         op0_byp_mux_sel_Dhl = stage_q[rs_Dhl];
      if (rt_hit_w && eff_ready_w[rt_Dhl])
         op1_byp_mux_sel_Dhl = stage_q[rt_Dhl];

      stall_hazard_Dhl = inst_val_Dhl && (rs_unrdy_w || rt_unrdy_w);
   end

   always_comb begin
      count_d = count_q;
      if (inst_val_Dhl && stall_hazard_Dhl)
         count_d = count_q + 32'd1;
   end

   assign hazard_stall_count = count_q;

   // Control state is reset; stage/fu payload is qualified by pending and needs none.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         ready_q   <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         ready_q   <= ready_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      stage_q <= stage_d;
      fu_q    <= fu_d;
   end

endmodule

// File: tb/tb_parc_core_scoreboard.sv
// Directed bench for parc_core_scoreboard: bypass selects, RAW stall and
// stall counter across ALU, load, muldiv, WAW, r0 and reset scenarios.
module tb_parc_core_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_val_Dhl;
   logic [4:0]  rs_Dhl, rt_Dhl, rd_Dhl;
   logic        rs_en_Dhl, rt_en_Dhl, wen_Dhl;
   logic [1:0]  fu_Dhl;
   logic        issue_Dhl;
   logic        advance_Xhl, advance_Mhl, advance_Whl;
   logic        muldivresp_val_Xhl, dmemresp_val_Mhl;
   logic [1:0]  op0_byp_mux_sel_Dhl, op1_byp_mux_sel_Dhl;
   logic        stall_hazard_Dhl;
   logic [31:0] hazard_stall_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   parc_core_scoreboard dut (
      .clk                 (clk),
      .reset               (reset),
      .inst_val_Dhl        (inst_val_Dhl),
      .rs_Dhl              (rs_Dhl),
      .rt_Dhl              (rt_Dhl),
      .rs_en_Dhl           (rs_en_Dhl),
      .rt_en_Dhl           (rt_en_Dhl),
      .rd_Dhl              (rd_Dhl),
      .wen_Dhl             (wen_Dhl),
      .fu_Dhl              (fu_Dhl),
      .issue_Dhl           (issue_Dhl),
      .advance_Xhl         (advance_Xhl),
      .advance_Mhl         (advance_Mhl),
      .advance_Whl         (advance_Whl),
      .muldivresp_val_Xhl  (muldivresp_val_Xhl),
      .dmemresp_val_Mhl    (dmemresp_val_Mhl),
      .op0_byp_mux_sel_Dhl (op0_byp_mux_sel_Dhl),
      .op1_byp_mux_sel_Dhl (op1_byp_mux_sel_Dhl),
      .stall_hazard_Dhl    (stall_hazard_Dhl),
      .hazard_stall_count  (hazard_stall_count)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; inst_val_Dhl = 1'b0;
      rs_Dhl = '0; rt_Dhl = '0; rd_Dhl = '0;
      rs_en_Dhl = 1'b0; rt_en_Dhl = 1'b0; wen_Dhl = 1'b0;
      fu_Dhl = '0; issue_Dhl = 1'b0;
      advance_Xhl = 1'b1; advance_Mhl = 1'b1; advance_Whl = 1'b1;
      muldivresp_val_Xhl = 1'b0; dmemresp_val_Mhl = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [1:0] fu);
      inst_val_Dhl = 1'b1; issue_Dhl = 1'b1; wen_Dhl = 1'b1;
      rd_Dhl = rd; fu_Dhl = fu;
   endtask

   task automatic no_issue();
      issue_Dhl = 1'b0; wen_Dhl = 1'b0; rd_Dhl = '0; fu_Dhl = '0;
   endtask

   task automatic read_rs(input logic [4:0] r);
      inst_val_Dhl = 1'b1; rs_Dhl = r; rs_en_Dhl = 1'b1;
   endtask

   task automatic read_rt(input logic [4:0] r);
      inst_val_Dhl = 1'b1; rt_Dhl = r; rt_en_Dhl = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      settle();
      check_val("rst_op0", 32'(op0_byp_mux_sel_Dhl), 32'd0);
      check_val("rst_op1", 32'(op1_byp_mux_sel_Dhl), 32'd0);
      check_val("rst_stall", 32'(stall_hazard_Dhl), 32'd0);
      check_val("rst_count", hazard_stall_count, 32'd0);

      // ALU chain on r3
      issue(5'd3, 2'd0);
      step(); no_issue(); read_rs(5'd3); settle();
      check_val("alu_t1_sel", 32'(op0_byp_mux_sel_Dhl), 32'd1);
      check_val("alu_t1_stall", 32'(stall_hazard_Dhl), 32'd0);
      step(); settle();
      check_val("alu_t2_sel", 32'(op0_byp_mux_sel_Dhl), 32'd2);
      step(); settle();
      check_val("alu_t3_sel", 32'(op0_byp_mux_sel_Dhl), 32'd3);
      step(); settle();
      check_val("alu_t4_sel", 32'(op0_byp_mux_sel_Dhl), 32'd0);
      check_val("alu_count", hazard_stall_count, 32'd0);

      // Load-use on r5
      do_reset();
      issue(5'd5, 2'd1);
      step(); no_issue(); read_rs(5'd5); settle();
      check_val("ld_t1_stall", 32'(stall_hazard_Dhl), 32'd1);
      check_val("ld_t1_sel", 32'(op0_byp_mux_sel_Dhl), 32'd0);
      step(); dmemresp_val_Mhl = 1'b1; settle();
      check_val("ld_t2_sel", 32'(op0_byp_mux_sel_Dhl), 32'd2);
      check_val("ld_t2_stall", 32'(stall_hazard_Dhl), 32'd0);
      check_val("ld_t2_count", hazard_stall_count, 32'd1);
      step(); dmemresp_val_Mhl = 1'b0; settle();
      check_val("ld_t3_sel_held", 32'(op0_byp_mux_sel_Dhl), 32'd3);

      // Muldiv 4-cycle on r7, read through rt
      do_reset();
      issue(5'd7, 2'd2);
      step(); no_issue(); advance_Xhl = 1'b0; read_rt(5'd7); settle();
      check_val("md_t1_stall", 32'(stall_hazard_Dhl), 32'd1);
      step(); settle();
      check_val("md_t2_stall", 32'(stall_hazard_Dhl), 32'd1);
      step(); settle();
      check_val("md_t3_stall", 32'(stall_hazard_Dhl), 32'd1);
      step(); muldivresp_val_Xhl = 1'b1; settle();
      check_val("md_t4_sel", 32'(op1_byp_mux_sel_Dhl), 32'd1);
      check_val("md_t4_stall", 32'(stall_hazard_Dhl), 32'd0);
      check_val("md_t4_count", hazard_stall_count, 32'd3);
      advance_Xhl = 1'b1;
      step(); muldivresp_val_Xhl = 1'b0; settle();
      check_val("md_t5_sel", 32'(op1_byp_mux_sel_Dhl), 32'd2);

      // WAW: lw r2 then addu r2
      do_reset();
      issue(5'd2, 2'd1);
      step(); issue(5'd2, 2'd0);
      step(); no_issue(); read_rs(5'd2); settle();
      check_val("waw_t2_sel", 32'(op0_byp_mux_sel_Dhl), 32'd1);
      check_val("waw_t2_stall", 32'(stall_hazard_Dhl), 32'd0);
      step(); settle();
      check_val("waw_t3_sel", 32'(op0_byp_mux_sel_Dhl), 32'd2);
      step(); settle();
      check_val("waw_t4_sel", 32'(op0_byp_mux_sel_Dhl), 32'd3);
      step(); settle();
      check_val("waw_t5_sel", 32'(op0_byp_mux_sel_Dhl), 32'd0);

      // r0 destination and disabled source
      do_reset();
      issue(5'd0, 2'd2);
      step(); issue(5'd9, 2'd1);
      step(); no_issue();
      advance_Xhl = 1'b0; advance_Mhl = 1'b0; advance_Whl = 1'b0;
      read_rs(5'd0); rt_Dhl = 5'd9; rt_en_Dhl = 1'b0; inst_val_Dhl = 1'b1; settle();
      check_val("r0_op0", 32'(op0_byp_mux_sel_Dhl), 32'd0);
      check_val("r0_op1", 32'(op1_byp_mux_sel_Dhl), 32'd0);
      check_val("r0_stall", 32'(stall_hazard_Dhl), 32'd0);
      rt_en_Dhl = 1'b1; settle();
      check_val("r9_en_stall", 32'(stall_hazard_Dhl), 32'd1);
      inst_val_Dhl = 1'b0; settle();
      check_val("r9_noval_stall", 32'(stall_hazard_Dhl), 32'd0);

      // Reset mid-stall
      do_reset();
      issue(5'd7, 2'd2);
      step(); no_issue(); advance_Xhl = 1'b0; read_rs(5'd7); settle();
      check_val("rms_pre_stall", 32'(stall_hazard_Dhl), 32'd1);
      reset = 1'b1;
      step(); reset = 1'b0; settle();
      check_val("rms_stall", 32'(stall_hazard_Dhl), 32'd0);
      check_val("rms_op0", 32'(op0_byp_mux_sel_Dhl), 32'd0);
      check_val("rms_count", hazard_stall_count, 32'd0);

      // Re-issue to r4 on the edge the old r4 retires from W
      do_reset();
      issue(5'd4, 2'd0);
      step(); no_issue(); read_rs(5'd4);
      step();
      step(); settle();
      check_val("reiss_w_sel", 32'(op0_byp_mux_sel_Dhl), 32'd3);
      issue(5'd4, 2'd1);
      step(); no_issue(); read_rs(5'd4); settle();
      check_val("reiss_stall", 32'(stall_hazard_Dhl), 32'd1);
      check_val("reiss_sel", 32'(op0_byp_mux_sel_Dhl), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
